// File: rtl/bus_master.sv
// bus_master: synth control bus initiator.
// One host request becomes one bus cycle with a single BusClock pulse.
module bus_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [15:0] ReqAddr,
  input  logic [7:0]  ReqData,
  output logic        RespValid,
  output logic [7:0]  RespData,
  output logic [15:0] BusAddress,
  inout  wire  [7:0]  BusData,
  output logic        BusReadWrite,
  output logic        BusClock
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    HOLD,
    TURN
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        clk_q, clk_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        drv_q, drv_d;
  logic        rvld_q, rvld_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        rdy_q, rdy_d;

  assign BusData      = drv_q ? data_q : 8'bz;
  assign BusAddress   = addr_q;
  assign BusReadWrite = rw_q;
  assign BusClock     = clk_q;
  assign RespValid    = rvld_q;
  assign RespData     = rdat_q;
  assign ReqReady     = rdy_q;

  // Phase sequencing, bus field latching and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drv_d   = drv_q;
    rvld_d  = 1'b0;
    rdat_d  = rdat_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        drv_d = 1'b1;
        if (ReqValid && rdy_q) begin
          state_d = SETUP;
          cnt_d   = RELOAD;
          addr_d  = ReqAddr;
          data_d  = ReqData;
          rw_d    = ReqWrite;
          drv_d   = ReqWrite;
          rdy_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = RELOAD;
          clk_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = RELOAD;
          clk_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          rvld_d = 1'b1;
          cnt_d  = '0;
          if (rw_q) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end else begin
            state_d = TURN;
            rdat_d  = BusData;
            rw_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
        drv_d   = 1'b1;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      drv_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drv_q   <= drv_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule
